// File: rtl/seq_alu_unit.sv
// Handshaked sequential ALU: single-cycle SUB/NAND, bit-serial leading-ones count
// and one-hot decode over the concatenated operand pair {B,A}.
module seq_alu_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_overflow,
    output logic             o_err
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned IW = $clog2(DW);
    localparam int unsigned CW = IW + 1;
    localparam logic [CW-1:0] LastIdx = CW'(DW - 1);

    localparam logic [1:0] OpSub   = 2'b00;
    localparam logic [1:0] OpNand  = 2'b01;
    localparam logic [1:0] OpLones = 2'b10;
    localparam logic [1:0] OpOhdec = 2'b11;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [DW-1:0]   opnd_q;
    logic [CW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   pos_q;
    logic            found_q;
    logic [1:0]      nset_q;
    logic [WIDTH-1:0] y_q;
    logic            ovf_q;
    logic            err_q;

    logic            cur_bit;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   pos_next;
    logic            found_next;
    logic [1:0]      nset_next;
    logic            lones_done;
    logic            ohdec_done;
    logic [WIDTH-1:0] sub_y;
    logic            sub_ovf;

    always_comb begin
        cur_bit    = opnd_q[idx_q[IW-1:0]];
        cnt_next   = cnt_q + CW'(cur_bit);
        found_next = found_q | cur_bit;
        pos_next   = (cur_bit && !found_q) ? idx_q : pos_q;
        // Set-bit count saturates at 2: only "exactly one" matters.
        nset_next  = (cur_bit && nset_q != 2'd2) ? nset_q + 2'd1 : nset_q;
        lones_done = !cur_bit || (idx_q == '0);
        ohdec_done = (idx_q == LastIdx);
        sub_y      = i_a - i_b;
        sub_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (i_a[WIDTH-1] != sub_y[WIDTH-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            op_q    <= 2'b00;
            opnd_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            found_q <= 1'b0;
            nset_q  <= 2'd0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        op_q    <= i_op;
                        opnd_q  <= {i_b, i_a};
                        cnt_q   <= '0;
                        pos_q   <= '0;
                        found_q <= 1'b0;
                        nset_q  <= 2'd0;
                        unique case (i_op)
                            OpSub: begin
                                y_q     <= sub_y;
                                ovf_q   <= sub_ovf;
                                err_q   <= 1'b0;
                                state_q <= StDone;
                            end
                            OpNand: begin
                                y_q     <= ~(i_a & i_b);
                                ovf_q   <= 1'b0;
                                err_q   <= 1'b0;
                                state_q <= StDone;
                            end
                            OpLones: begin
                                idx_q   <= LastIdx;
                                state_q <= StScan;
                            end
                            OpOhdec: begin
                                idx_q   <= '0;
                                state_q <= StScan;
                            end
                            default: state_q <= StIdle;
                        endcase
                    end
                end
                StScan: begin
                    if (op_q == OpLones) begin
                        cnt_q <= cnt_next;
                        idx_q <= idx_q - 1'b1;
                        if (lones_done) begin
                            y_q     <= WIDTH'(cnt_next);
                            ovf_q   <= (cnt_next >> WIDTH) != '0;
                            err_q   <= 1'b0;
                            state_q <= StDone;
                        end
                    end else begin
                        found_q <= found_next;
                        pos_q   <= pos_next;
                        nset_q  <= nset_next;
                        idx_q   <= idx_q + 1'b1;
                        if (ohdec_done) begin
                            y_q     <= found_next ? WIDTH'(pos_next) : '0;
                            ovf_q   <= (pos_next >> WIDTH) != '0;
                            err_q   <= (nset_next != 2'd1);
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ready    = (state_q == StIdle);
    assign o_valid    = (state_q == StDone);
    assign o_y        = y_q;
    assign o_overflow = ovf_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit: directed cases plus randomized transactions
// checked against an arithmetic reference model.
module tb_seq_alu_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in, ready_out, valid_out, ready_in;
    logic [1:0] op;
    logic [3:0] a, b, y;
    logic       ovf, err;

    logic       v2, r2_out, vo2, ri2;
    logic [1:0] op2;
    logic [1:0] a2, b2, y2;
    logic       ovf2, err2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_alu_unit #(.WIDTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready_out), .i_op(op),
        .i_a(a), .i_b(b), .o_valid(valid_out), .i_ready(ready_in), .o_y(y),
        .o_overflow(ovf), .o_err(err)
    );

    seq_alu_unit #(.WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(r2_out), .i_op(op2),
        .i_a(a2), .i_b(b2), .o_valid(vo2), .i_ready(ri2), .o_y(y2),
        .o_overflow(ovf2), .o_err(err2)
    );

    // Reference model for WIDTH=4, expressed directly in terms of integer arithmetic.
    function automatic void model(input logic [1:0] m_op, input logic [3:0] m_a, m_b,
                                  output logic [3:0] m_y, output logic m_ovf, m_err,
                                  output int m_lat);
        logic [7:0] v;
        int         d, k, pos, n;
        bit         stop, found;
        v     = {m_b, m_a};
        m_ovf = 1'b0;
        m_err = 1'b0;
        m_y   = 4'h0;
        m_lat = 1;
        case (m_op)
            2'd0: begin
                d     = int'($signed(m_a)) - int'($signed(m_b));
                m_y   = 4'(d);
                m_ovf = (d > 7) || (d < -8);
            end
            2'd1: m_y = ~(m_a & m_b);
            2'd2: begin
                k    = 0;
                stop = 0;
                for (int i = 7; i >= 0; i--) begin
                    if (!stop) begin
                        if (v[i]) k++;
                        else stop = 1;
                    end
                end
                m_y   = 4'(k);
                m_ovf = (k > 15);
                m_lat = 1 + ((k < 8) ? k + 1 : 8);
            end
            default: begin
                n     = $countones(v);
                pos   = 0;
                found = 0;
                for (int i = 0; i < 8; i++) begin
                    if (v[i] && !found) begin
                        pos   = i;
                        found = 1;
                    end
                end
                m_y   = 4'(pos);
                m_ovf = (pos > 15);
                m_err = (n != 1);
                m_lat = 9;
            end
        endcase
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        valid_in = 1'b0; ready_in = 1'b0; op = 2'd0; a = 4'h0; b = 4'h0;
        v2 = 1'b0; ri2 = 1'b0; op2 = 2'd0; a2 = 2'd0; b2 = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issue one transaction, scramble inputs after acceptance, wait (bounded) for o_valid.
    task automatic do_txn(input logic [1:0] t_op, input logic [3:0] t_a, t_b, output int lat);
        int w;
        w = 0;
        while (!ready_out && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        op = t_op; a = t_a; b = t_b; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
        lat = 1;
        while (!valid_out && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({ready_out, valid_out, y, ovf, err} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset: rdy/vld/y/ovf/err got %b/%b/%h/%b/%b want 1/0/0/0/0",
                     ready_out, valid_out, y, ovf, err);
        end
    endtask

    task automatic test_sub();
        int lat;
        do_txn(2'd0, 4'h7, 4'hF, lat);
        tests++;
        if ({y, ovf, err} !== {4'h8, 1'b1, 1'b0} || lat != 1) begin
            fails++;
            $display("FAIL sub_7_F: y/ovf/err/lat got %h/%b/%b/%0d want 8/1/0/1", y, ovf, err, lat);
        end
        release_result();
        tests++;
        if ({valid_out, ready_out} !== 2'b01) begin
            fails++;
            $display("FAIL sub_release: vld/rdy got %b/%b want 0/1", valid_out, ready_out);
        end
    endtask

    task automatic test_nand_hold();
        int lat;
        do_txn(2'd1, 4'hC, 4'hA, lat);
        tests++;
        if ({y, ovf, err} !== {4'h7, 1'b0, 1'b0} || lat != 1) begin
            fails++;
            $display("FAIL nand_C_A: y/ovf/err/lat got %h/%b/%b/%0d want 7/0/0/1", y, ovf, err, lat);
        end
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
            @(posedge clk); #1;
            tests++;
            if ({valid_out, ready_out, y, ovf, err} !== {1'b1, 1'b0, 4'h7, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL nand_hold[%0d]: vld/rdy/y/ovf/err got %b/%b/%h/%b/%b want 1/0/7/0/0",
                         i, valid_out, ready_out, y, ovf, err);
            end
        end
        valid_in = 1'b0;
        release_result();
    endtask

    task automatic test_lones();
        logic [3:0] tb_b [2] = '{4'hE, 4'hF};
        logic [3:0] ta   [2] = '{4'h0, 4'hF};
        logic [3:0] ey   [2] = '{4'd3, 4'd8};
        int         elat [2] = '{5, 9};
        int         lat;
        for (int i = 0; i < 2; i++) begin
            do_txn(2'd2, ta[i], tb_b[i], lat);
            tests++;
            if ({y, ovf, err} !== {ey[i], 1'b0, 1'b0} || lat != elat[i]) begin
                fails++;
                $display("FAIL lones[%0d]: y/ovf/err/lat got %h/%b/%b/%0d want %h/0/0/%0d",
                         i, y, ovf, err, lat, ey[i], elat[i]);
            end
            release_result();
        end
    endtask

    task automatic test_lones_w2();
        int lat;
        op2 = 2'd2; a2 = 2'h3; b2 = 2'h3; v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        lat = 1;
        while (!vo2 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if ({y2, ovf2, err2} !== {2'd0, 1'b1, 1'b0} || lat != 5) begin
            fails++;
            $display("FAIL lones_w2: y/ovf/err/lat got %h/%b/%b/%0d want 0/1/0/5",
                     y2, ovf2, err2, lat);
        end
        ri2 = 1'b1;
        @(posedge clk); #1;
        ri2 = 1'b0;
    endtask

    task automatic test_ohdec();
        logic [3:0] tb_b [4] = '{4'h0, 4'h8, 4'h1, 4'h0};
        logic [3:0] ta   [4] = '{4'h4, 4'h0, 4'h1, 4'h0};
        logic [3:0] ey   [4] = '{4'd2, 4'd7, 4'd0, 4'd0};
        logic       eerr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int         lat;
        for (int i = 0; i < 4; i++) begin
            do_txn(2'd3, ta[i], tb_b[i], lat);
            tests++;
            if ({y, ovf, err} !== {ey[i], 1'b0, eerr[i]} || lat != 9) begin
                fails++;
                $display("FAIL ohdec[%0d]: y/ovf/err/lat got %h/%b/%b/%0d want %h/0/%b/9",
                         i, y, ovf, err, lat, ey[i], eerr[i]);
            end
            release_result();
        end
    endtask

    task automatic test_random();
        logic [1:0] r_op;
        logic [3:0] r_a, r_b, ey;
        logic       eovf, eerr;
        int         elat, lat;
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = 4'($urandom);
            r_b  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            model(r_op, r_a, r_b, ey, eovf, eerr, elat);
            do_txn(r_op, r_a, r_b, lat);
            tests++;
            if ({y, ovf, err} !== {ey, eovf, eerr} || lat != elat) begin
                fails++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: y/ovf/err/lat got %h/%b/%b/%0d want %h/%b/%b/%0d",
                         i, r_op, r_a, r_b, y, ovf, err, lat, ey, eovf, eerr, elat);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_result();
        end
    endtask

    task automatic test_reset_scan();
        int lat;
        bit seen;
        op = 2'd3; a = 4'h4; b = 4'h0; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({valid_out, ready_out, y, ovf, err} !== {1'b0, 1'b1, 4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_scan: vld/rdy/y/ovf/err got %b/%b/%h/%b/%b want 0/1/0/0/0",
                     valid_out, ready_out, y, ovf, err);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (valid_out) seen = 1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL reset_scan_discard: o_valid got 1 want 0");
        end
        do_txn(2'd0, 4'h3, 4'h5, lat);
        tests++;
        if ({y, ovf, err} !== {4'hE, 1'b0, 1'b0} || lat != 1) begin
            fails++;
            $display("FAIL reset_scan_sub: y/ovf/err/lat got %h/%b/%b/%0d want e/0/0/1", y, ovf, err, lat);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [1:0] bo [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
        logic [3:0] ba [4], bb [4], ey [4];
        logic       eovf [4], eerr [4];
        int         elat, acc, res;
        logic       rdy_before, prev_valid;
        for (int i = 0; i < 4; i++) begin
            ba[i] = 4'($urandom);
            bb[i] = (i == 1) ? 4'hF : 4'($urandom);
            model(bo[i], ba[i], bb[i], ey[i], eovf[i], eerr[i], elat);
        end
        acc = 0; res = 0; prev_valid = 1'b0;
        ready_in = 1'b1;
        op = bo[0]; a = ba[0]; b = bb[0]; valid_in = 1'b1;
        for (int cyc = 0; cyc < 200 && res < 4; cyc++) begin
            rdy_before = ready_out;
            @(posedge clk); #1;
            if (rdy_before && valid_in) begin
                acc++;
                if (acc < 4) begin
                    op = bo[acc]; a = ba[acc]; b = bb[acc];
                end else begin
                    valid_in = 1'b0;
                end
            end
            if (prev_valid) begin
                tests++;
                if ({valid_out, ready_out} !== 2'b01) begin
                    fails++;
                    $display("FAIL b2b_reidle: vld/rdy got %b/%b want 0/1", valid_out, ready_out);
                end
            end
            if (valid_out) begin
                tests++;
                if ({y, ovf, err} !== {ey[res], eovf[res], eerr[res]}) begin
                    fails++;
                    $display("FAIL b2b[%0d]: y/ovf/err got %h/%b/%b want %h/%b/%b",
                             res, y, ovf, err, ey[res], eovf[res], eerr[res]);
                end
                res++;
            end
            prev_valid = valid_out;
        end
        @(posedge clk); #1;
        tests++;
        if ({valid_out, ready_out} !== 2'b01 || res != 4 || acc != 4) begin
            fails++;
            $display("FAIL b2b_count: vld/rdy/results/accepts got %b/%b/%0d/%0d want 0/1/4/4",
                     valid_out, ready_out, res, acc);
        end
        valid_in = 1'b0;
        ready_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sub();
        test_nand_hold();
        test_lones();
        test_lones_w2();
        test_ohdec();
        test_random();
        test_reset_scan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
